collatz_seq: RTL and testbench



---
 rtl/collatz_seq.sv | 116 +++++++++++
 tb/tb_collatz_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_seq.sv
// Collatz sequence engine: loads n on go, iterates one step per clock
// until 1, tracking step count and peak, flagging zero/overflow/saturation.
module collatz_seq #(
  parameter int WIDTH  = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [WIDTH-1:0]  n,
  output logic [WIDTH-1:0]  dout,
  output logic [CWIDTH-1:0] steps,
  output logic [WIDTH-1:0]  peak,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_dout;
  logic [WIDTH-1:0]    w_dout_nxt;
  logic [CWIDTH-1:0]   r_steps;
  logic [CWIDTH-1:0]   w_steps_nxt;
  logic [WIDTH-1:0]    r_peak;
  logic [WIDTH-1:0]    w_peak_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic [WIDTH+1:0]    w_tri;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_step;
  logic                w_sat;

  // 3n+1 carried in two extra bits so overflow is visible, never written back
  assign w_tri  = {2'b00, r_dout}
                + {1'b0, r_dout, 1'b0}
                + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_ovf  = |w_tri[WIDTH+1:WIDTH];
  assign w_step = r_dout[0] ? w_tri[WIDTH-1:0]
                            : {1'b0, r_dout[WIDTH-1:1]};
  assign w_sat  = &r_steps;

  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_steps_nxt = r_steps;
    w_peak_nxt  = r_peak;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE, DONE: begin
        if (go) begin
          w_state_nxt = RUN;
          w_dout_nxt  = n;
          w_peak_nxt  = n;
          w_steps_nxt = '0;
          w_err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (r_dout == '0) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
        end else if (r_dout == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b0;
        end else if (w_sat) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
        end else if (r_dout[0] && w_ovf) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_dout_nxt  = w_step;
          w_steps_nxt = r_steps + {{(CWIDTH-1){1'b0}}, 1'b1};
          if (w_step > r_peak) begin
            w_peak_nxt = w_step;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_steps <= '0;
      r_peak  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_steps <= w_steps_nxt;
      r_peak  <= w_peak_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign dout  = r_dout;
  assign steps = r_steps;
  assign peak  = r_peak;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign err   = r_err;

endmodule

// File: tb/tb_collatz_seq.sv
// Directed bench for collatz_seq: three instances cover
// WIDTH=32, WIDTH=8 and CWIDTH=2 configurations.
module tb_collatz_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        go32;
  logic [31:0] n32, d32, p32;
  logic [15:0] s32;
  logic        b32, dn32, e32;

  logic        go8;
  logic [7:0]  n8, d8, p8;
  logic [15:0] s8;
  logic        b8, dn8, e8;

  logic        goc;
  logic [31:0] nc, dc, pc;
  logic [1:0]  sc;
  logic        bc, dnc, ec;

  collatz_seq #(.WIDTH(32), .CWIDTH(16)) u32 (
    .clk(clk), .reset(reset), .go(go32), .n(n32),
    .dout(d32), .steps(s32), .peak(p32),
    .busy(b32), .done(dn32), .err(e32)
  );

  collatz_seq #(.WIDTH(8), .CWIDTH(16)) u8 (
    .clk(clk), .reset(reset), .go(go8), .n(n8),
    .dout(d8), .steps(s8), .peak(p8),
    .busy(b8), .done(dn8), .err(e8)
  );

  collatz_seq #(.WIDTH(32), .CWIDTH(2)) uc (
    .clk(clk), .reset(reset), .go(goc), .n(nc),
    .dout(dc), .steps(sc), .peak(pc),
    .busy(bc), .done(dnc), .err(ec)
  );

  // packed views: {busy, done, err, steps, peak, dout}
  function automatic logic [82:0] st32();
    return {b32, dn32, e32, s32, p32, d32};
  endfunction

  function automatic logic [34:0] st8();
    return {b8, dn8, e8, s8, p8, d8};
  endfunction

  function automatic logic [68:0] stc();
    return {bc, dnc, ec, sc, pc, dc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [82:0] e;
    reset = 1'b1;
    go32 = 1'b1; n32 = 32'd6;
    go8 = 1'b1; n8 = 8'd6;
    goc = 1'b1; nc = 32'd6;
    tick();
    e = '0;
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL reset32 got=%h exp=%h", st32(), e);
    end
    tests++;
    if (st8() !== 35'd0 || stc() !== 69'd0) begin
      fails++;
      $display("FAIL reset_others got=%h/%h exp=0", st8(), stc());
    end
    reset = 1'b0;
    go32 = 1'b0; go8 = 1'b0; goc = 1'b0;
    tick();
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL idle_hold got=%h exp=%h", st32(), e);
    end
  endtask

  task automatic test_n6();
    int seq [9] = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
    logic [82:0] e;
    n32 = 32'd6; go32 = 1'b1;
    tick();
    go32 = 1'b0;
    e = {1'b1, 1'b0, 1'b0, 16'd0, 32'd6, 32'd6};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL n6_load got=%h exp=%h", st32(), e);
    end
    for (int i = 1; i < 9; i++) begin
      tick();
      tests++;
      if (d32 !== 32'(seq[i]) || b32 !== 1'b1) begin
        fails++;
        $display("FAIL n6_step%0d got=%0d busy=%b exp=%0d",
                 i, d32, b32, seq[i]);
      end
    end
    tick();
    e = {1'b0, 1'b1, 1'b0, 16'd8, 32'd16, 32'd1};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL n6_done got=%h exp=%h", st32(), e);
    end
  endtask

  task automatic test_n27();
    logic [82:0] e;
    int cnt;
    n32 = 32'd27; go32 = 1'b1;
    tick();
    go32 = 1'b0;
    cnt = 0;
    while (!dn32 && cnt < 300) begin
      go32 = (cnt == 5 || cnt == 50);
      n32 = 32'd5;
      tick();
      cnt++;
    end
    go32 = 1'b0;
    tests++;
    if (cnt !== 112) begin
      fails++;
      $display("FAIL n27_latency got=%0d exp=112", cnt);
    end
    e = {1'b0, 1'b1, 1'b0, 16'd111, 32'd9232, 32'd1};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL n27_done got=%h exp=%h", st32(), e);
    end
  endtask

  task automatic test_w8();
    logic [34:0] e;
    int cnt;
    n8 = 8'd255; go8 = 1'b1;
    tick();
    go8 = 1'b0;
    tick();
    e = {1'b0, 1'b1, 1'b1, 16'd0, 8'd255, 8'd255};
    tests++;
    if (st8() !== e) begin
      fails++;
      $display("FAIL w8_255 got=%h exp=%h", st8(), e);
    end
    n8 = 8'd85; go8 = 1'b1;
    tick();
    go8 = 1'b0;
    tick();
    e = {1'b0, 1'b1, 1'b1, 16'd0, 8'd85, 8'd85};
    tests++;
    if (st8() !== e) begin
      fails++;
      $display("FAIL w8_85 got=%h exp=%h", st8(), e);
    end
    n8 = 8'd84; go8 = 1'b1;
    tick();
    go8 = 1'b0;
    tick();
    e = {1'b1, 1'b0, 1'b0, 16'd1, 8'd84, 8'd42};
    tests++;
    if (st8() !== e) begin
      fails++;
      $display("FAIL w8_84_first got=%h exp=%h", st8(), e);
    end
    cnt = 0;
    while (!dn8 && cnt < 100) begin
      tick();
      cnt++;
    end
    e = {1'b0, 1'b1, 1'b0, 16'd9, 8'd84, 8'd1};
    tests++;
    if (st8() !== e) begin
      fails++;
      $display("FAIL w8_84_done got=%h exp=%h", st8(), e);
    end
  endtask

  task automatic test_bounds();
    logic [82:0] e;
    logic [68:0] ec2;
    n32 = 32'd1; go32 = 1'b1;
    tick();
    go32 = 1'b0;
    tick();
    e = {1'b0, 1'b1, 1'b0, 16'd0, 32'd1, 32'd1};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL n1 got=%h exp=%h", st32(), e);
    end
    n32 = 32'd0; go32 = 1'b1;
    tick();
    go32 = 1'b0;
    tick();
    e = {1'b0, 1'b1, 1'b1, 16'd0, 32'd0, 32'd0};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL n0 got=%h exp=%h", st32(), e);
    end
    nc = 32'd6; goc = 1'b1;
    tick();
    goc = 1'b0;
    tick(); tick(); tick();
    ec2 = {1'b1, 1'b0, 1'b0, 2'd3, 32'd10, 32'd5};
    tests++;
    if (stc() !== ec2) begin
      fails++;
      $display("FAIL cw2_step3 got=%h exp=%h", stc(), ec2);
    end
    tick();
    ec2 = {1'b0, 1'b1, 1'b1, 2'd3, 32'd10, 32'd5};
    tests++;
    if (stc() !== ec2) begin
      fails++;
      $display("FAIL cw2_sat got=%h exp=%h", stc(), ec2);
    end
  endtask

  task automatic test_back_to_back();
    logic [82:0] e;
    int cnt;
    n32 = 32'd6; go32 = 1'b1;
    tick();
    n32 = 32'd3;
    for (int i = 0; i < 9; i++) tick();
    e = {1'b0, 1'b1, 1'b0, 16'd8, 32'd16, 32'd1};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL b2b_first got=%h exp=%h", st32(), e);
    end
    tick();
    go32 = 1'b0;
    e = {1'b1, 1'b0, 1'b0, 16'd0, 32'd3, 32'd3};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL b2b_reload got=%h exp=%h", st32(), e);
    end
    cnt = 0;
    while (!dn32 && cnt < 100) begin
      tick();
      cnt++;
    end
    e = {1'b0, 1'b1, 1'b0, 16'd7, 32'd16, 32'd1};
    tests++;
    if (st32() !== e || cnt !== 8) begin
      fails++;
      $display("FAIL b2b_done got=%h cyc=%0d exp=%h cyc=8",
               st32(), cnt, e);
    end
  endtask

  task automatic test_reset_midrun();
    logic [82:0] e;
    n32 = 32'd27; go32 = 1'b1;
    tick();
    go32 = 1'b0;
    tick(); tick(); tick(); tick();
    e = {1'b1, 1'b0, 1'b0, 16'd4, 32'd124, 32'd62};
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL mid_step4 got=%h exp=%h", st32(), e);
    end
    reset = 1'b1; go32 = 1'b1;
    tick();
    e = '0;
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL mid_reset got=%h exp=%h", st32(), e);
    end
    reset = 1'b0; go32 = 1'b0;
    tick();
    tests++;
    if (st32() !== e) begin
      fails++;
      $display("FAIL mid_idle got=%h exp=%h", st32(), e);
    end
  endtask

  initial begin
    test_reset();
    test_n6();
    test_n27();
    test_w8();
    test_bounds();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
